// File: rtl/layer_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_serializer_pkg
// Brief    : Shared state type and index-width helper for layer_serializer.
// Revision : 1.0
// ============================================================================
package layer_serializer_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } ser_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/argmax_tracker.sv
`default_nettype none
// ============================================================================
// Module   : argmax_tracker
// Brief    : Running signed maximum over a serialized frame; ties keep the
//            lower index, result published one cycle after the last word.
// Revision : 1.0
// ============================================================================
module argmax_tracker
    import layer_serializer_pkg::*;
#(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_clear,
    input  logic                                 i_update,
    input  logic [DATA_WIDTH-1:0]                i_value,
    input  logic [idx_width(NUM_NEURON)-1:0]     i_index,
    input  logic                                 i_done,
    output logic [idx_width(NUM_NEURON)-1:0]     o_argmax,
    output logic                                 o_argmax_valid
);

    localparam int IDX_W = idx_width(NUM_NEURON);

    logic [DATA_WIDTH-1:0] r_max;
    logic [IDX_W-1:0]      r_max_idx;
    logic                  r_have;
    logic                  w_take;
    logic [IDX_W-1:0]      w_best_idx;

    // Strict greater-than keeps the earlier (lower) index on ties.
    assign w_take     = i_update && (!r_have || ($signed(i_value) > $signed(r_max)));
    assign w_best_idx = w_take ? i_index : r_max_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max          <= '0;
            r_max_idx      <= '0;
            r_have         <= 1'b0;
            o_argmax       <= '0;
            o_argmax_valid <= 1'b0;
        end else begin
            o_argmax_valid <= 1'b0;
            if (i_clear) begin
                r_have <= 1'b0;
            end else if (i_update) begin
                if (w_take) begin
                    r_max     <= i_value;
                    r_max_idx <= i_index;
                    r_have    <= 1'b1;
                end
                if (i_done) begin
                    o_argmax       <= w_best_idx;
                    o_argmax_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_serializer.sv
`default_nettype none
// ============================================================================
// Module   : layer_serializer
// Brief    : Collects one word per neuron into a frame buffer, then streams
//            the frame in index order. LAYER_SERIALIZER_ARGMAX_EN adds argmax.
// Revision : 1.0
// ============================================================================
module layer_serializer
    import layer_serializer_pkg::*;
#(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0]     i_data,
    input  logic [NUM_NEURON-1:0]                i_data_valid,
    output logic [DATA_WIDTH-1:0]                o_data,
    output logic                                 o_data_valid,
    input  logic                                 i_data_ready,
    output logic                                 o_last,
    output logic                                 o_busy,
    output logic                                 o_overrun,
    output logic [idx_width(NUM_NEURON)-1:0]     o_argmax,
    output logic                                 o_argmax_valid
);

    localparam int               IDX_W      = idx_width(NUM_NEURON);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_NEURON - 1);

    ser_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_buf [NUM_NEURON];
    logic [NUM_NEURON-1:0] r_mask;
    logic [IDX_W-1:0]      r_idx;

    logic                  w_xfer;
    logic                  w_start;
    logic                  w_frame_done;
    logic [IDX_W-1:0]      w_idx_next;
    logic [DATA_WIDTH-1:0] w_first_word;

    assign w_xfer       = o_data_valid & i_data_ready;
    assign w_start      = (r_state == COLLECT) && (&(r_mask | i_data_valid));
    assign w_frame_done = w_xfer & o_last;
    assign w_idx_next   = r_idx + 1'b1;
    // Word 0 may arrive on the very edge that completes the frame.
    assign w_first_word = i_data_valid[0] ? i_data[DATA_WIDTH-1:0] : r_buf[0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= COLLECT;
            r_mask       <= '0;
            r_idx        <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_last       <= 1'b0;
            o_busy       <= 1'b0;
            o_overrun    <= 1'b0;
            for (int k = 0; k < NUM_NEURON; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    for (int k = 0; k < NUM_NEURON; k++) begin
                        if (i_data_valid[k]) begin
                            r_buf[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if (|(i_data_valid & r_mask)) begin
                        o_overrun <= 1'b1;
                    end
                    if (w_start) begin
                        r_state      <= SEND;
                        r_mask       <= '0;
                        r_idx        <= '0;
                        o_data       <= w_first_word;
                        o_data_valid <= 1'b1;
                        o_last       <= 1'b0;
                        o_busy       <= 1'b1;
                    end else begin
                        r_mask <= r_mask | i_data_valid;
                    end
                end
                SEND: begin
                    // Buffer is frozen while sending; late words are dropped.
                    if (|i_data_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (w_frame_done) begin
                        r_state      <= COLLECT;
                        r_idx        <= '0;
                        o_data_valid <= 1'b0;
                        o_last       <= 1'b0;
                        o_busy       <= 1'b0;
                    end else if (w_xfer) begin
                        r_idx  <= w_idx_next;
                        o_data <= r_buf[w_idx_next];
                        o_last <= (w_idx_next == C_LAST_IDX);
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

`ifdef LAYER_SERIALIZER_ARGMAX_EN
    argmax_tracker #(
        .NUM_NEURON (NUM_NEURON),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_argmax (
        .clk            (i_clk),
        .rst            (i_reset),
        .i_clear        (w_start),
        .i_update       (w_xfer),
        .i_value        (o_data),
        .i_index        (r_idx),
        .i_done         (w_frame_done),
        .o_argmax       (o_argmax),
        .o_argmax_valid (o_argmax_valid)
    );
`else
    assign o_argmax       = '0;
    assign o_argmax_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_serializer
// Brief    : Directed and randomized bench for layer_serializer (4 x 16-bit).
// Revision : 1.0
// ============================================================================
module tb_layer_serializer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*DW-1:0] data;
    logic [N-1:0]  dv;
    logic          rdy;
    logic [DW-1:0] odata;
    logic          ovalid, olast, obusy, oovr, oargv;
    logic [IW-1:0] oarg;

    always #5 clk = ~clk;

    layer_serializer #(.NUM_NEURON(N), .DATA_WIDTH(DW)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_data         (data),
        .i_data_valid   (dv),
        .o_data         (odata),
        .o_data_valid   (ovalid),
        .i_data_ready   (rdy),
        .o_last         (olast),
        .o_busy         (obusy),
        .o_overrun      (oovr),
        .o_argmax       (oarg),
        .o_argmax_valid (oargv)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame gathered in an array, then sent from a queue.
    logic [DW-1:0] m_buf   [N];
    logic [DW-1:0] m_frame [N];
    logic [N-1:0]  m_mask;
    bit            m_sending;
    logic [DW-1:0] m_q [$];
    bit            m_ovr;
    logic [IW-1:0] m_arg;
    bit            m_argv;

    function automatic logic [IW-1:0] frame_argmax();
        int best = 0;
        for (int i = 1; i < N; i++) begin
            if ($signed(m_frame[i]) > $signed(m_frame[best])) best = i;
        end
        return IW'(best);
    endfunction

    function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                              input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_buf[k]   = '0;
            m_frame[k] = '0;
        end
        m_mask    = '0;
        m_sending = 1'b0;
        m_q.delete();
        m_ovr     = 1'b0;
        m_arg     = '0;
        m_argv    = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("valid", ovalid, m_sending);
        check_eq("busy", obusy, m_sending);
        check_eq("last", olast, m_sending && (m_q.size() == 1));
        if (m_sending) check_eq("data", odata, m_q[0]);
        check_eq("overrun", oovr, m_ovr);
`ifdef LAYER_SERIALIZER_ARGMAX_EN
        check_eq("argmax_valid", oargv, m_argv);
        check_eq("argmax", oarg, m_arg);
`else
        check_eq("argmax_valid", oargv, 1'b0);
        check_eq("argmax", oarg, '0);
`endif
    endtask

    // One clock: check current outputs, drive inputs, advance model and DUT.
    task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
        check_outputs();
        dv   = v;
        data = d;
        rdy  = r;
        m_argv = 1'b0;
        if (m_sending) begin
            if (v != '0) m_ovr = 1'b1;
            if (r) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_sending = 1'b0;
                    m_arg     = frame_argmax();
                    m_argv    = 1'b1;
                end
            end
        end else begin
            if ((v & m_mask) != '0) m_ovr = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (v[k]) m_buf[k] = d[k*DW +: DW];
            end
            m_mask = m_mask | v;
            if (&m_mask) begin
                m_sending = 1'b1;
                for (int k = 0; k < N; k++) begin
                    m_q.push_back(m_buf[k]);
                    m_frame[k] = m_buf[k];
                end
                m_mask = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dv  = '0;
        #1;
        model_reset();
        check_eq("rst_data", odata, '0);
        check_eq("rst_valid", ovalid, 1'b0);
        check_eq("rst_last", olast, 1'b0);
        check_eq("rst_busy", obusy, 1'b0);
        check_eq("rst_overrun", oovr, 1'b0);
        check_eq("rst_argmax", oarg, '0);
        check_eq("rst_argmax_valid", oargv, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        dv   = '0;
        data = '0;
        rdy  = 1'b0;
        do_reset();

        // All four words in one cycle, ready held high.
        cycle(4'hF, pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040), 1'b1);
        for (int i = 0; i < 6; i++) cycle('0, '0, 1'b1);

        // Staggered valids: neurons 2,0,3,1 at cycles 0,3,5,9.
        for (int c = 0; c < 10; c++) begin
            logic [N-1:0] v;
            v = (c == 0) ? 4'b0100 : (c == 3) ? 4'b0001 :
                (c == 5) ? 4'b1000 : (c == 9) ? 4'b0010 : 4'b0000;
            cycle(v, pack4(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03), 1'b1);
        end
        check_eq("latency_valid", ovalid, 1'b1);
        check_eq("latency_word0", odata, 16'h0A00);
        for (int i = 0; i < 6; i++) cycle('0, '0, 1'b1);

        // Backpressure on word 1 for three cycles.
        cycle(4'hF, pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444), 1'b0);
        cycle('0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle('0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle('0, '0, 1'b1);

        // Overrun during SEND, then a clean frame.
        cycle(4'hF, pack4(16'h0005, 16'h0006, 16'h0007, 16'h0008), 1'b1);
        cycle(4'b0001, pack4(16'hFFFF, 16'h0, 16'h0, 16'h0), 1'b1);
        for (int i = 0; i < 4; i++) cycle('0, '0, 1'b1);
        cycle(4'hF, pack4(16'h0051, 16'h0052, 16'h0053, 16'h0054), 1'b1);
        for (int i = 0; i < 6; i++) cycle('0, '0, 1'b1);

        // Signed argmax with a tie at the top.
        cycle(4'hF, pack4(16'h0100, 16'hFF00, 16'h0300, 16'h0300), 1'b1);
        for (int i = 0; i < 6; i++) cycle('0, '0, 1'b1);

        // Reset after two words, then a fresh frame.
        cycle(4'hF, pack4(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04), 1'b1);
        cycle('0, '0, 1'b1);
        cycle('0, '0, 1'b1);
        do_reset();
        cycle(4'hF, pack4(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04), 1'b1);
        for (int i = 0; i < 6; i++) cycle('0, '0, 1'b1);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0]    v;
            logic [N*DW-1:0] d;
            v = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            d = {$urandom, $urandom};
            cycle(v, d, ($urandom_range(0, 3) != 0));
        end
        cycle('0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
